// File: rtl/float7_pkg.sv
// Shared constants, FSM state type and reference decode for the 7-bit compact float.
package float7_pkg;

    localparam int unsigned EXP_W   = 3;
    localparam int unsigned MAN_W   = 4;
    localparam int unsigned INT_W   = 11;
    localparam int unsigned MAX_INT = 1984;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Pure decode of {exp, man} to the unsigned integer it represents.
    function automatic logic [INT_W-1:0] f7_to_int(input logic [EXP_W-1:0] e,
                                                   input logic [MAN_W-1:0] m);
        if (e == '0) begin
            return INT_W'(m);
        end
        return INT_W'({1'b1, m}) << (e - EXP_W'(1));
    endfunction

endpackage

// File: rtl/float7_unpack.sv
// Splits a compact float into the shifter seed and the number of left shifts still owed.
module float7_unpack #(
    parameter int unsigned EXP_W = 3,
    parameter int unsigned MAN_W = 4,
    parameter int unsigned INT_W = 11
) (
    input  logic [EXP_W-1:0] exp,
    input  logic [MAN_W-1:0] man,
    output logic [INT_W-1:0] acc_init,
    output logic [EXP_W-1:0] cnt_init
);

    // Denormal codes carry no hidden one and need no shifting.
    always_comb begin
        acc_init = '0;
        cnt_init = '0;
        if (exp == '0) begin
            acc_init = INT_W'(man);
        end else begin
            acc_init = INT_W'({1'b1, man});
            cnt_init = exp - EXP_W'(1);
        end
    end

endmodule

// File: rtl/float7_to_int11_seq.sv
// Iterative compact-float to integer decoder, one shift per cycle, valid/ready on both sides.
module float7_to_int11_seq #(
    parameter int unsigned EXP_W = float7_pkg::EXP_W,
    parameter int unsigned MAN_W = float7_pkg::MAN_W,
    parameter int unsigned INT_W = float7_pkg::INT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W-1:0] in_man,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_int,
    output logic             busy
);

    generate
        if (INT_W != MAN_W + 1 + (2 ** EXP_W - 2)) begin : g_bad_int_w
            $error("float7_to_int11_seq: INT_W must equal MAN_W+1+(2**EXP_W-2)");
        end
    endgenerate

    float7_pkg::state_t state;
    logic [INT_W-1:0]   acc;
    logic [EXP_W-1:0]   cnt;
    logic [INT_W-1:0]   acc_init;
    logic [EXP_W-1:0]   cnt_init;
    logic               accept;

    float7_unpack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .INT_W (INT_W)
    ) u_unpack (
        .exp      (in_exp),
        .man      (in_man),
        .acc_init (acc_init),
        .cnt_init (cnt_init)
    );

    // Ready in IDLE, and in DONE exactly when the result is leaving this cycle.
    assign in_ready = (state == float7_pkg::IDLE) ||
                      ((state == float7_pkg::DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != float7_pkg::IDLE);
    assign out_int  = acc;

    // FSM, shift counter and accumulator; a load may coincide with an output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= float7_pkg::IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                acc <= acc_init;
                cnt <= cnt_init;
                if (cnt_init == '0) begin
                    state     <= float7_pkg::DONE;
                    out_valid <= 1'b1;
                end else begin
                    state     <= float7_pkg::SHIFT;
                    out_valid <= 1'b0;
                end
            end else begin
                case (state)
                    float7_pkg::SHIFT: begin
                        acc <= {acc[INT_W-2:0], 1'b0};
                        cnt <= cnt - EXP_W'(1);
                        if (cnt == EXP_W'(1)) begin
                            state     <= float7_pkg::DONE;
                            out_valid <= 1'b1;
                        end
                    end
                    float7_pkg::DONE: begin
                        if (out_ready) begin
                            state     <= float7_pkg::IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                    float7_pkg::IDLE: begin
                        out_valid <= 1'b0;
                    end
                    default: begin
                        state     <= float7_pkg::IDLE;
                        out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_float7_to_int11_seq.sv
// Self-checking bench for float7_to_int11_seq: directed table, full code sweep, random ops, corner sequences.
module tb_float7_to_int11_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_exp;
    logic [3:0]  in_man;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_int;
    logic        busy;

    int n_checks;
    int n_fail;

    float7_to_int11_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned e;
        int unsigned m;
        int unsigned stall;
        int unsigned want;
        int unsigned lat;
    } vec_t;

    vec_t vecs[6];

    // Value of a code straight from the format definition.
    function automatic int unsigned ref_int(input int unsigned e, input int unsigned m);
        if (e == 0) return m;
        return (16 + m) * (2 ** (e - 1));
    endfunction

    function automatic int unsigned ref_lat(input int unsigned e);
        return (e == 0) ? 0 : e - 1;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // One complete transaction from IDLE, with optional output backpressure.
    task automatic do_op(input int unsigned e, input int unsigned m, input int unsigned stall,
                         input int unsigned want, input int unsigned lat);
        int unsigned j;
        bit          seen;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 1);
        in_valid  = 1'b1;
        in_exp    = 3'(e);
        in_man    = 4'(m);
        out_ready = 1'b0;
        @(negedge clk);
        j    = 0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            check("shift_in_ready", 32'(in_ready), 0);
            check("shift_busy", 32'(busy), 1);
            in_valid = 1'b1;
            in_exp   = 3'($urandom);
            in_man   = 4'($urandom);
            @(negedge clk);
            j++;
        end
        check("out_valid_timeout", 32'(seen), 1);
        check("latency", j, lat);
        check("out_int", 32'(out_int), want);
        for (int s = 0; s < int'(stall); s++) begin
            in_valid = 1'b1;
            in_exp   = 3'($urandom);
            in_man   = 4'($urandom);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_out_int", 32'(out_int), want);
            check("stall_in_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", 32'(out_valid), 0);
        check("post_busy", 32'(busy), 0);
    endtask

    initial begin
        int unsigned e, m, st;
        int unsigned b2b_e[5];
        int unsigned b2b_m[5];

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_exp    = '0;
        in_man    = '0;
        out_ready = 1'b0;

        vecs[0] = '{e: 0, m: 9,  stall: 0, want: 9,    lat: 0};
        vecs[1] = '{e: 3, m: 5,  stall: 0, want: 84,   lat: 2};
        vecs[2] = '{e: 7, m: 15, stall: 0, want: 1984, lat: 6};
        vecs[3] = '{e: 2, m: 3,  stall: 5, want: 38,   lat: 1};
        vecs[4] = '{e: 1, m: 0,  stall: 2, want: 16,   lat: 0};
        vecs[5] = '{e: 0, m: 0,  stall: 1, want: 0,    lat: 0};

        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_int", 32'(out_int), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table of hand-computed results.
        foreach (vecs[i]) begin
            do_op(vecs[i].e, vecs[i].m, vecs[i].stall, vecs[i].want, vecs[i].lat);
        end

        // Every code against the format definition, and the package helper too.
        for (int c = 0; c < 128; c++) begin
            e = 32'(c) >> 4;
            m = 32'(c) & 32'hF;
            check("pkg_f7_to_int", 32'(float7_pkg::f7_to_int(3'(e), 4'(m))), ref_int(e, m));
            do_op(e, m, 0, ref_int(e, m), ref_lat(e));
        end

        // Random codes with random backpressure.
        for (int r = 0; r < 40; r++) begin
            e  = $urandom_range(7, 0);
            m  = $urandom_range(15, 0);
            st = $urandom_range(3, 0);
            do_op(e, m, st, ref_int(e, m), ref_lat(e));
        end

        // Back-to-back short codes with out_ready tied high: a new result every cycle.
        b2b_e = '{1, 0, 1, 0, 1};
        b2b_m = '{0, 5, 7, 15, 0};
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_exp    = 3'(b2b_e[0]);
        in_man    = 4'(b2b_m[0]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b2b_out_valid", 32'(out_valid), 1);
            check("b2b_out_int", 32'(out_int), ref_int(b2b_e[i], b2b_m[i]));
            check("b2b_in_ready", 32'(in_ready), 1);
            if (i < 4) begin
                in_exp = 3'(b2b_e[i+1]);
                in_man = 4'(b2b_m[i+1]);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_end_out_valid", 32'(out_valid), 0);
        check("b2b_end_busy", 32'(busy), 0);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        in_valid = 1'b1;
        in_exp   = 3'd6;
        in_man   = 4'd11;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out_int", 32'(out_int), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 1, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
